// File: rtl/serializador.sv
// Double-buffered byte serializer: holding register feeds an 8-bit shifter, MSB first, one-cycle gap per frame.
// Optional even-parity bit after bit0 when SERIALIZADOR_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line quiet, waiting for a byte in the holding register
// SHIFT  | data_out carries bit cnt_q of the frame, cnt_q counts 7 down to 0
// PARITY | data_out carries even parity of the frame (SERIALIZADOR_PARITY_EN only)
// GAP    | one-cycle frame delimiter, next byte may be transferred on its closing edge
module serializador (
    input  logic       clk_100KHz,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       load_in,
    output logic       ack_out,
    output logic       data_out,
    output logic       write_out,
    output logic       status_out,
    output logic       busy_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIALIZADOR_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif
    localparam logic [1:0] GAP    = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [7:0] hold_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       data_d;
    logic       write_d;
    logic       capture;
    logic       transfer;

    // status_out is 1 on every transfer edge, so capture and transfer are exclusive
    assign capture = load_in && !status_out;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = 1'b0;
        write_d  = 1'b0;
        transfer = 1'b0;

        case (state_q)
            IDLE: begin
                if (status_out) begin
                    transfer = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d   = cnt_q - 3'd1;
                    data_d  = shift_q[cnt_q - 3'd1];
                    write_d = 1'b1;
                end else begin
`ifdef SERIALIZADOR_PARITY_EN
                    state_d = PARITY;
                    data_d  = ^shift_q;
                    write_d = 1'b1;
`else
                    state_d = GAP;
`endif
                end
            end
`ifdef SERIALIZADOR_PARITY_EN
            PARITY: begin
                state_d = GAP;
            end
`endif
            GAP: begin
                if (status_out) begin
                    transfer = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (transfer) begin
            state_d = SHIFT;
            shift_d = hold_q;
            cnt_d   = 3'd7;
            data_d  = hold_q[7];
            write_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100KHz) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            hold_q     <= 8'd0;
            shift_q    <= 8'd0;
            data_out   <= 1'b0;
            write_out  <= 1'b0;
            ack_out    <= 1'b0;
            status_out <= 1'b0;
            busy_out   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_out  <= data_d;
            write_out <= write_d;
            busy_out  <= (state_d != IDLE);
            ack_out   <= capture;
            if (capture) begin
                hold_q     <= data_in;
                status_out <= 1'b1;
            end else if (transfer) begin
                status_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador: frame-queue model compared every cycle plus literal frame checks.
module tb_serializador;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load_in;
    logic       ack_out;
    logic       data_out;
    logic       write_out;
    logic       status_out;
    logic       busy_out;

    int errors = 0;
    int checks = 0;

    serializador dut (
        .clk_100KHz (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_in    (load_in),
        .ack_out    (ack_out),
        .data_out   (data_out),
        .write_out  (write_out),
        .status_out (status_out),
        .busy_out   (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer expands the held byte into a queue of line symbols {write,data}
    logic [1:0] line_q[$];
    logic [1:0] cur     = 2'b00;
    bit         m_full  = 0;
    bit         m_busy  = 0;
    bit         m_ack   = 0;
    logic [7:0] m_hold  = 8'd0;
    bit         started = 0;

    always @(posedge clk) begin
        bit cap;
        bit xfer;
        started = 1;
        if (!reset) begin
            line_q.delete();
            cur    = 2'b00;
            m_full = 0;
            m_busy = 0;
            m_ack  = 0;
            m_hold = 8'd0;
        end else begin
            cap  = load_in && !m_full;
            xfer = m_full && (line_q.size() == 0);
            if (xfer) begin
                for (int i = 7; i >= 0; i--) line_q.push_back({1'b1, m_hold[i]});
`ifdef SERIALIZADOR_PARITY_EN
                line_q.push_back({1'b1, ^m_hold});
`endif
                line_q.push_back(2'b00);
                m_full = 0;
            end
            if (line_q.size() > 0) begin
                cur    = line_q.pop_front();
                m_busy = 1;
            end else begin
                cur    = 2'b00;
                m_busy = 0;
            end
            if (cap) begin
                m_full = 1;
                m_hold = data_in;
            end
            m_ack = cap;
        end
    end

    // Compare against the model and log frames seen on the line
    logic [15:0] acc      = 16'd0;
    int          nbits    = 0;
    int          zero_run = 0;
    int          ack_cnt  = 0;
    logic [15:0] frames[$];
    int          frame_len[$];
    int          gaps[$];

    always @(negedge clk) begin
        if (started) begin
            check("ack_out",    ack_out,    m_ack);
            check("write_out",  write_out,  cur[1]);
            check("data_out",   data_out,   cur[0]);
            check("status_out", status_out, m_full);
            check("busy_out",   busy_out,   m_busy);
            if (ack_out) ack_cnt++;
            if (write_out) begin
                if (zero_run > 0 && frames.size() > 0) gaps.push_back(zero_run);
                zero_run = 0;
                acc      = {acc[14:0], data_out};
                nbits++;
            end else begin
                zero_run++;
                if (nbits > 0) begin
                    frames.push_back(acc);
                    frame_len.push_back(nbits);
                    acc   = 16'd0;
                    nbits = 0;
                end
            end
        end
    end

    task automatic load_byte(input logic [7:0] b, output int waited);
        data_in = b;
        load_in = 1'b1;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack_out && waited < 40);
        check("ack_seen", ack_out, 1);
        load_in = 1'b0;
        data_in = 8'd0;
    endtask

    task automatic wait_status_clear();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (status_out && n < 40);
        check("status_clear", status_out, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_out || status_out || write_out) && n < 80);
        check("wait_idle", busy_out, 0);
        #1;
    endtask

    task automatic clear_log();
        frames.delete();
        frame_len.delete();
        gaps.delete();
    endtask

    initial begin
        int w;
        int a0;
        int n;
        reset   = 1'b0;
        load_in = 1'b0;
        data_in = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_write",  write_out,  0);
        check("rst_status", status_out, 0);
        check("rst_busy",   busy_out,   0);
        reset = 1'b1;
        @(negedge clk);

        // 0xA5 from IDLE: ack in the cycle after capture, bit7 one cycle later
        load_byte(8'hA5, w);
        check("a5_ack_latency", w, 1);
        @(negedge clk);
        check("a5_first_write", write_out, 1);
        check("a5_first_bit",   data_out,  1);
        wait_idle();
        check("a5_nframes", frames.size(), 1);
        if (frames.size() >= 1) begin
            check("a5_frame", frames[0], 16'h00A5);
            check("a5_len",   frame_len[0], 8);
        end
        clear_log();

        // back-to-back 0x3C then 0xC3 with a single gap cycle
        load_byte(8'h3C, w);
        wait_status_clear();
        load_byte(8'hC3, w);
        wait_idle();
        check("b2b_nframes", frames.size(), 2);
        if (frames.size() >= 2) begin
            check("b2b_frame0", frames[0], 16'h003C);
            check("b2b_frame1", frames[1], 16'h00C3);
        end
        check("b2b_ngaps", gaps.size(), 1);
        if (gaps.size() >= 1) check("b2b_gap_len", gaps[0], 1);
        clear_log();

        // load held high with 0xFF while holding is full
        load_byte(8'h5A, w);
        wait_status_clear();
        load_byte(8'h11, w);
        #1;
        a0      = ack_cnt;
        data_in = 8'hFF;
        load_in = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("ff_no_ack", ack_cnt, a0);
        load_in = 1'b0;
        data_in = 8'd0;
        wait_idle();
        check("ff_nframes", frames.size(), 2);
        if (frames.size() >= 2) begin
            check("ff_frame0", frames[0], 16'h005A);
            check("ff_frame1", frames[1], 16'h0011);
        end
        clear_log();

        // reset after the 4th bit of 0x81 with 0x42 waiting in the holding register
        load_byte(8'h81, w);
        wait_status_clear();
        load_byte(8'h42, w);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (nbits != 4 && n < 40);
        check("rst_mid_reached", nbits, 4);
        reset   = 1'b0;
        load_in = 1'b1;
        data_in = 8'h77;
        @(negedge clk);
        check("rst_mid_write",  write_out,  0);
        check("rst_mid_status", status_out, 0);
        check("rst_mid_busy",   busy_out,   0);
        check("rst_mid_ack",    ack_out,    0);
        @(negedge clk);
        reset   = 1'b1;
        load_in = 1'b0;
        data_in = 8'd0;
        repeat (25) @(negedge clk);
        #1;
        check("rst_mid_nframes", frames.size(), 1);
        if (frames.size() >= 1) begin
            check("rst_mid_partial", frames[0], 16'h0008);
            check("rst_mid_plen",    frame_len[0], 4);
        end
        clear_log();

`ifdef SERIALIZADOR_PARITY_EN
        load_byte(8'h07, w);
        wait_idle();
        load_byte(8'h03, w);
        wait_idle();
        check("par_nframes", frames.size(), 2);
        if (frames.size() >= 2) begin
            check("par_frame0", frames[0], 16'h000F);
            check("par_len0",   frame_len[0], 9);
            check("par_frame1", frames[1], 16'h0006);
        end
        clear_log();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
